// File: rtl/alu_scheduler_if.sv
`timescale 1ns/1ps
// Requester handshakes plus the shared-ALU operand/result bus, as seen by alu_scheduler.
// The slave modport is the scheduler's view; master is the environment's view.
interface alu_scheduler_if;
  logic       i_req0;
  logic       i_req1;
  logic [2:0] i_op0;
  logic [2:0] i_op1;
  logic [7:0] i_a0;
  logic [7:0] i_b0;
  logic [7:0] i_a1;
  logic [7:0] i_b1;
  logic [7:0] i_alu_result;
  logic       i_alu_comp;
  logic [7:0] o_alu_data1;
  logic [7:0] o_alu_data2;
  logic [2:0] o_alu_select;
  logic       o_gnt0;
  logic       o_gnt1;
  logic       o_done0;
  logic       o_done1;
  logic [7:0] o_result_out;
  logic       o_zero_out;
  logic       o_busy;

  modport slave (
    input  i_req0, i_req1, i_op0, i_op1, i_a0, i_b0, i_a1, i_b1,
    input  i_alu_result, i_alu_comp,
    output o_alu_data1, o_alu_data2, o_alu_select,
    output o_gnt0, o_gnt1, o_done0, o_done1,
    output o_result_out, o_zero_out, o_busy
  );

  modport master (
    output i_req0, i_req1, i_op0, i_op1, i_a0, i_b0, i_a1, i_b1,
    output i_alu_result, i_alu_comp,
    input  o_alu_data1, o_alu_data2, o_alu_select,
    input  o_gnt0, o_gnt1, o_done0, o_done1,
    input  o_result_out, o_zero_out, o_busy
  );
endinterface

// File: rtl/alu_scheduler.sv
`timescale 1ns/1ps
// Two-requester scheduler for one shared multi-cycle ALU: round-robin grant on contention,
// operands held on the ALU bus for the opcode's latency, result captured on completion.
module alu_scheduler #(
  parameter int LAT_LOGIC = 1,
  parameter int LAT_ADD   = 2,
  parameter int LAT_MUL   = 3
) (
  input  logic           clk,
  input  logic           rst,
  alu_scheduler_if.slave bus
);

  localparam int LAT_AM  = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
  localparam int LAT_MAX = (LAT_LOGIC > LAT_AM) ? LAT_LOGIC : LAT_AM;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;
  logic             r_last;
  logic             w_lastNext;
  logic             r_owner;
  logic             w_ownerNext;
  logic [2:0]       r_aluSelect;
  logic [2:0]       w_selNext;
  logic [7:0]       r_aluData1;
  logic [7:0]       w_data1Next;
  logic [7:0]       r_aluData2;
  logic [7:0]       w_data2Next;
  logic [7:0]       r_result;
  logic [7:0]       w_resultNext;
  logic             r_zero;
  logic             w_zeroNext;
  logic             r_gnt0;
  logic             w_gnt0Next;
  logic             r_gnt1;
  logic             w_gnt1Next;
  logic             r_done0;
  logic             w_done0Next;
  logic             r_done1;
  logic             w_done1Next;

  logic             w_anyReq;
  logic             w_winner;
  logic [2:0]       w_winOp;
  logic [7:0]       w_winA;
  logic [7:0]       w_winB;

  function automatic logic [CNT_W-1:0] latencyOf(input logic [2:0] op);
    case (op)
      3'b001:  return CNT_W'(LAT_ADD);
      3'b100:  return CNT_W'(LAT_MUL);
      default: return CNT_W'(LAT_LOGIC);
    endcase
  endfunction

  // On contention the requester that was not granted last wins; r_last starts at 1 so requester 0 goes first.
  assign w_anyReq = bus.i_req0 | bus.i_req1;
  assign w_winner = (bus.i_req0 & bus.i_req1) ? ~r_last : bus.i_req1;
  assign w_winOp  = w_winner ? bus.i_op1 : bus.i_op0;
  assign w_winA   = w_winner ? bus.i_a1  : bus.i_a0;
  assign w_winB   = w_winner ? bus.i_b1  : bus.i_b0;

  always_comb begin
    w_stateNext  = r_state;
    w_cntNext    = r_cnt;
    w_lastNext   = r_last;
    w_ownerNext  = r_owner;
    w_selNext    = r_aluSelect;
    w_data1Next  = r_aluData1;
    w_data2Next  = r_aluData2;
    w_resultNext = r_result;
    w_zeroNext   = r_zero;
    w_gnt0Next   = 1'b0;
    w_gnt1Next   = 1'b0;
    w_done0Next  = 1'b0;
    w_done1Next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_anyReq) begin
          w_selNext   = w_winOp;
          w_data1Next = w_winA;
          w_data2Next = w_winB;
          w_cntNext   = latencyOf(w_winOp);
          w_lastNext  = w_winner;
          w_ownerNext = w_winner;
          w_gnt0Next  = ~w_winner;
          w_gnt1Next  = w_winner;
          w_stateNext = EXEC;
        end
      end
      EXEC: begin
        // Requests are ignored here; the ALU bus stays frozen until the count expires.
        w_cntNext = r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_resultNext = bus.i_alu_result;
          w_zeroNext   = bus.i_alu_comp;
          w_done0Next  = ~r_owner;
          w_done1Next  = r_owner;
          w_stateNext  = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_last      <= 1'b1;
      r_owner     <= 1'b0;
      r_aluSelect <= '0;
      r_aluData1  <= '0;
      r_aluData2  <= '0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_cnt       <= w_cntNext;
      r_last      <= w_lastNext;
      r_owner     <= w_ownerNext;
      r_aluSelect <= w_selNext;
      r_aluData1  <= w_data1Next;
      r_aluData2  <= w_data2Next;
      r_result    <= w_resultNext;
      r_zero      <= w_zeroNext;
      r_gnt0      <= w_gnt0Next;
      r_gnt1      <= w_gnt1Next;
      r_done0     <= w_done0Next;
      r_done1     <= w_done1Next;
    end
  end

  assign bus.o_alu_select = r_aluSelect;
  assign bus.o_alu_data1  = r_aluData1;
  assign bus.o_alu_data2  = r_aluData2;
  assign bus.o_result_out = r_result;
  assign bus.o_zero_out   = r_zero;
  assign bus.o_gnt0       = r_gnt0;
  assign bus.o_gnt1       = r_gnt1;
  assign bus.o_done0      = r_done0;
  assign bus.o_done1      = r_done1;
  assign bus.o_busy       = (r_state != IDLE);

endmodule

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 The block SHALL have parameter LAT_LOGIC, default 1: EXEC cycles for forward/AND/OR and unsupported opcodes (min 1).
REQ-002 The block SHALL have parameter LAT_ADD, default 2: EXEC cycles for add, opcode 3'b001 (min 1).
REQ-003 The block SHALL have parameter LAT_MUL, default 3: EXEC cycles for multiply, opcode 3'b100 (min 1).
REQ-004 CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 REQ0, REQ1  input  1 each  operation request from requester 0 / 1.
REQ-007 OP0, OP1  input  3 each  ALU opcode of each requester.
REQ-008 A0, B0, A1, B1  input  8 each  operands; A maps to ALU DATA1, B to DATA2.
REQ-009 ALU_DATA1, ALU_DATA2  output  8 each  registered operands driven to the shared ALU.
REQ-010 ALU_SELECT  output  3  registered opcode driven to the ALU.
REQ-011 ALU_RESULT  input  8  ALU result; ALU_COMP  input  1  ALU zero flag.
REQ-012 GNT0, GNT1  output  1 each  one-cycle pulse: request accepted, operands captured.
REQ-013 DONE0, DONE1  output  1 each  one-cycle pulse: result valid for that requester.
REQ-014 RESULT_OUT  output  8  result of the last completed operation; ZERO_OUT  output  1  captured ALU_COMP.
REQ-015 BUSY  output  1  high whenever state is not IDLE.

Function
REQ-016 The block SHALL implement states IDLE and EXEC; all outputs SHALL be registered except BUSY, which is decoded from state.
REQ-017 In IDLE, at a rising edge with REQ0 or REQ1 high, the block SHALL latch the winner's OP/A/B into ALU_SELECT/ALU_DATA1/ALU_DATA2, pulse the winner's GNT for the following cycle, load CNT with the opcode latency, and enter EXEC.
REQ-018 With exactly one request high, that request SHALL win.
REQ-019 With both requests high, the requester not granted last SHALL win; LAST register updated on every grant.
REQ-020 In EXEC, CNT SHALL decrement each edge; at the edge where CNT==1, the block SHALL capture RESULT_OUT<=ALU_RESULT and ZERO_OUT<=ALU_COMP, pulse the owner's DONE for one cycle, and return to IDLE.
REQ-021 DONE SHALL be asserted exactly L cycles after the corresponding GNT cycle (L = latency of the opcode); issue rate SHALL be at most one operation per L+1 cycles.
REQ-022 ALU_DATA1, ALU_DATA2 and ALU_SELECT SHALL remain constant from grant until the next grant; REQ/OP/A/B changes during EXEC SHALL be ignored.
REQ-023 Requesters SHALL hold REQ and operands until GNT and drop REQ before the next edge; a REQ still high in IDLE SHALL be treated as a new request.
REQ-024 Opcodes 3'b101-3'b111 SHALL be issued with latency LAT_LOGIC and complete normally, forwarding whatever the ALU returns.
REQ-025 GNT0/GNT1 SHALL never both be high; DONE0/DONE1 SHALL never both be high; a GNT SHALL never coincide with a DONE of the same requester.
REQ-026 RESULT_OUT and ZERO_OUT SHALL hold their value until the next completion.

Reset
REQ-027 RESET high SHALL immediately force state IDLE, CNT=0, LAST=1 (requester 0 wins the first contention), and GNT*, DONE*, ALU_DATA1, ALU_DATA2, ALU_SELECT, RESULT_OUT, ZERO_OUT all 0.
REQ-028 RESET asserted during EXEC SHALL abort the operation with no DONE pulse; after release the block SHALL accept requests from the first rising edge.

Verification
REQ-029 REQ0=1, OP0=001, A0=5, B0=3 -> GNT0 one cycle, ALU_SELECT=001, DATA 5/3; DONE0 two cycles later with RESULT_OUT=8, ZERO_OUT=0.
REQ-030 REQ0=REQ1=1 held for three operations (OP=000, B0=7, B1=9) -> grant order 0,1,0; RESULT_OUT 7,9,7; DONE spacing 2 cycles.
REQ-031 REQ1=1, OP1=100, A1=4, B1=6 -> DONE1 exactly 3 cycles after GNT1, RESULT_OUT=24; REQ0 raised mid-EXEC is granted only after the return to IDLE.
REQ-032 OP0=010, A0=8'hF0, B0=8'h0F -> RESULT_OUT=0, ZERO_OUT=1 after 1 cycle; OP0=111 -> completes after 1 cycle, RESULT_OUT=0.
REQ-033 RESET pulsed one cycle after GNT0 of a multiply -> no DONE0, all outputs 0, BUSY=0; a new REQ1 is granted on the first edge after release.
